// File: rtl/pipeline_stage_buffer.sv
// Elastic pipeline stage register: valid/ready on both sides, 2-entry skid, flush, NOP bubbles.
// Optional stall counter output enabled by defining STAGE_BUF_STALL_CNT_EN.
module pipeline_stage_buffer #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
`ifdef STAGE_BUF_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_out_valid;
    logic              w_skid_valid;
    logic [1:0]        w_count;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign in_ready   = !w_skid_valid && !flush && Clr_n;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = w_out_valid && out_ready;

    assign out_valid  = w_out_valid;
    assign out_data   = r_main;
    assign count      = w_count;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) w_state_nxt = S_ONE;
                end
                S_ONE: begin
                    if (w_in_xfer && !w_out_xfer)
                        w_state_nxt = S_FULL;
                    else if (!w_in_xfer && w_out_xfer)
                        w_state_nxt = S_EMPTY;
                end
                S_FULL: begin
                    if (w_out_xfer) w_state_nxt = S_ONE;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid  = 1'b0;
        w_skid_valid = 1'b0;
        w_count      = 2'd0;
        case (r_state)
            S_ONE: begin
                w_out_valid = 1'b1;
                w_count     = 2'd1;
            end
            S_FULL: begin
                w_out_valid  = 1'b1;
                w_skid_valid = 1'b1;
                w_count      = 2'd2;
            end
            default: begin
                w_out_valid  = 1'b0;
                w_skid_valid = 1'b0;
                w_count      = 2'd0;
            end
        endcase
    end

    // Main always falls back to NOP_VALUE when it empties, so out_data is a bubble.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_main <= NOP_VALUE;
            r_skid <= NOP_VALUE;
        end else if (flush) begin
            r_main <= NOP_VALUE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) r_main <= in_data;
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer)
                        r_main <= in_data;
                    else if (w_in_xfer)
                        r_skid <= in_data;
                    else if (w_out_xfer)
                        r_main <= NOP_VALUE;
                end
                S_FULL: begin
                    if (w_out_xfer) r_main <= r_skid;
                end
                default: ;
            endcase
        end
    end

`ifdef STAGE_BUF_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_out_valid && !out_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Scoreboard bench for pipeline_stage_buffer: directed scenarios plus a random phase.
// Define STAGE_BUF_STALL_CNT_EN to also exercise the stall counter.
module tb_pipeline_stage_buffer;

    localparam int unsigned DW  = 32;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    logic          Clk;
    logic          Clr_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    count;
`ifdef STAGE_BUF_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          seen77 = 1'b0;
    int            m_stall = 0;

    pipeline_stage_buffer #(
        .DATA_W   (DW),
        .NOP_VALUE(NOP)
    ) dut (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
`ifdef STAGE_BUF_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Mid-cycle monitor: transfers seen here complete on the next rising edge.
    always @(negedge Clk) begin
        if (!Clr_n) begin
            q.delete();
            prev_hold = 1'b0;
            m_stall   = 0;
        end else begin
            check("count", {30'd0, count}, q.size());
            check("in_ready", {31'd0, in_ready}, {31'd0, (!flush && q.size() < 2)});
            check("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
            if (!out_valid)
                check("nop_out", out_data, NOP);
            if (prev_hold) begin
                check("stable_v", {31'd0, out_valid}, 32'd1);
                check("stable_d", out_data, prev_data);
            end
            if (out_valid && out_data == 32'h77)
                seen77 = 1'b1;
            if (out_valid && !out_ready && m_stall != 16'hFFFF)
                m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0)
                        check("underflow", {31'd0, out_valid}, 32'd0);
                    else
                        check("sb_data", out_data, q.pop_front());
                end
                if (in_valid && in_ready)
                    q.push_back(in_data);
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_data = out_data;
        end
    end

    initial begin
        logic [DW-1:0] vals[4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};

        Clr_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, NOP);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_count", {30'd0, count}, 32'd0);
        step();
        Clr_n = 1'b1;
        #1;
        check("rel_ready", {31'd0, in_ready}, 32'd1);

        // 1: streaming, one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            step();
            check("t1_data", out_data, vals[i]);
            check("t1_count", {30'd0, count}, 32'd1);
            check("t1_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("t1_empty", {31'd0, out_valid}, 32'd0);

        // 2: backpressure fill and drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1;
        step();
        in_data = 32'hA2;
        step();
        check("t2_count", {30'd0, count}, 32'd2);
        check("t2_ready", {31'd0, in_ready}, 32'd0);
        check("t2_data", out_data, 32'hA1);
        in_data = 32'hA3;
        step();
        check("t2_hold", out_data, 32'hA1);
        check("t2_count2", {30'd0, count}, 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t2_pop1", out_data, 32'hA2);
        check("t2_cnt1", {30'd0, count}, 32'd1);
        step();
        check("t2_pop2v", {31'd0, out_valid}, 32'd0);
        check("t2_pop2d", out_data, NOP);

        // 3: simultaneous push/pop in ONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h05;
        step();
        check("t3_main", out_data, 32'h05);
        in_data   = 32'h06;
        out_ready = 1'b1;
        step();
        check("t3_data", out_data, 32'h06);
        check("t3_count", {30'd0, count}, 32'd1);
        in_valid = 1'b0;
        step();

        // 4: flush while FULL with a concurrent beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB1;
        step();
        in_data = 32'hB2;
        step();
        check("t4_full", {30'd0, count}, 32'd2);
        flush   = 1'b1;
        in_data = 32'h77;
        #1;
        check("t4_fl_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t4_count", {30'd0, count}, 32'd0);
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        check("t4_data", out_data, NOP);
        check("t4_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) step();
        check("t4_no77", {31'd0, seen77}, 32'd0);

        // 5: asynchronous reset between edges while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC1;
        step();
        in_data = 32'hC2;
        step();
        in_valid = 1'b0;
        check("t5_full", {30'd0, count}, 32'd2);
        #2;
        Clr_n = 1'b0;
        #1;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_data", out_data, NOP);
        check("t5_ready", {31'd0, in_ready}, 32'd0);
        check("t5_count", {30'd0, count}, 32'd0);
        repeat (2) step();
        Clr_n = 1'b1;
        #1;
        check("t5_rel", {31'd0, in_ready}, 32'd1);
        check("t5_relv", {31'd0, out_valid}, 32'd0);

`ifdef STAGE_BUF_STALL_CNT_EN
        // 6: stall counter
        check("t6_rst", {16'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hD1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("t6_ten", {16'd0, stall_cnt}, 32'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_flush", {16'd0, stall_cnt}, m_stall);
        repeat (3) step();
        check("t6_keep", {16'd0, stall_cnt}, 32'd11);
        in_valid = 1'b1;
        in_data  = 32'hE1;
        step();
        in_valid = 1'b0;
        repeat (70000) step();
        check("t6_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        out_ready = 1'b1;
        step();
`endif

        // random traffic, scoreboard only
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = $urandom;
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("drain", q.size(), 32'd0);
        check("drain_cnt", {30'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
Parametrised elastic pipeline stage register with a valid/ready handshake on both sides. It is the successor to the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries an arbitrary DATA_W bundle of stage data and control signals, and adds a 2-entry skid buffer for stall absorption, a synchronous flush, and NOP insertion on empty or flush. It drops in between any two pipeline stages of the ARM core.

Parameters:
DATA_W, 32, width of the data/control bundle carried per beat
NOP_VALUE, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0; encodes the stage's NOP control word

Ports:
Clk  input  1  clock, rising edge
Clr_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all held beats
in_valid  input  1  upstream beat valid
in_ready  output  1  buffer can accept a beat this cycle
in_data  input  DATA_W  upstream beat
out_valid  output  1  downstream beat valid (registered)
out_ready  input  1  downstream accepts the beat
out_data  output  DATA_W  downstream beat (registered)
count  output  2  number of held beats, 0..2

Behaviour:
- One clock domain. Clr_n is asynchronous and active-low: asserting it takes effect immediately, with no wait for Clk.
- Reset values: out_valid=0, out_data=NOP_VALUE, skid entry invalid, count=0. in_ready=0 while Clr_n=0; in_ready=1 from the first cycle after release.
- Storage is a main register, which drives out_data/out_valid, plus one skid register.
- Transfer definitions: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- in_ready = !skid_valid & !flush & Clr_n. It is combinational only on flush and Clr_n; skid_valid is a registered term.
- Latency: a beat accepted at edge N appears on out_data after edge N, i.e. 1 cycle, when the buffer was empty or draining.
- State machine, with count mirroring the state:
  EMPTY (0): input transfer -> ONE, main<=in_data.
  ONE (1): input and output transfer in the same cycle -> ONE, main<=in_data. Input transfer without output transfer -> FULL, skid<=in_data, main holds. Output transfer without input transfer -> EMPTY, out_data<=NOP_VALUE. Neither -> hold.
  FULL (2): in_ready=0. Output transfer -> ONE, main<=skid, skid invalid. Otherwise hold.
- Ordering is strict FIFO: no beat is lost, duplicated or reordered absent flush.
- Data stability: out_data and out_valid remain constant while out_valid=1 & out_ready=0.
- flush has the highest priority, below reset. On the next edge: state EMPTY, out_valid=0, out_data=NOP_VALUE, skid invalid, count=0. Any concurrent in_valid beat is not accepted, because in_ready=0. A concurrent out_ready is a don't-care; the bundle is dropped.
- Empty output: out_data equals NOP_VALUE whenever out_valid=0, so downstream control logic sees a bubble without needing to gate on out_valid.
- Reset mid-operation: all held beats are discarded immediately. No partial beat is emitted after release.

Optional Feature:
STAGE_BUF_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. It increments on every cycle with out_valid=1 & out_ready=0, and saturates at 16'hFFFF with no wrap. It is cleared only by Clr_n; flush does not clear it. Reset value is 0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset then stream: release Clr_n, in_valid=1 for 4 cycles with data 0x11,0x22,0x33,0x44, out_ready=1 -> out_data shows 0x11..0x44 on consecutive cycles, each 1 cycle after acceptance; count stays 1; in_ready=1 throughout.
2. Backpressure fill: out_ready=0, push 0xA1 then 0xA2 -> count=2, in_ready=0, out_data=0xA1 stable. Push 0xA3 while in_ready=0 -> not accepted. Then out_ready=1 -> outputs 0xA1, 0xA2, then out_valid=0 with out_data=NOP_VALUE.
3. Simultaneous push/pop in ONE: main=0x05, in_valid=1 data 0x06, out_ready=1 -> next cycle out_data=0x06, count=1, skid unused.
4. Flush when FULL, with in_valid=1 data 0x77 in the flush cycle -> next cycle count=0, out_valid=0, out_data=NOP_VALUE. 0x77 is never seen on out_data; in_ready=1 the cycle after flush.
5. Async reset mid-stream: drop Clr_n between edges with count=2 -> out_valid=0, out_data=NOP_VALUE and in_ready=0 immediately, before the next Clk edge.
6. With STAGE_BUF_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10; a flush leaves stall_cnt unchanged; forcing 70000 stall cycles -> stall_cnt=16'hFFFF.
